// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared constants and helpers for the streaming FIR filter.
//   - clog2           : ceiling log2, usable in parameter and port declarations
//   - DEF_DATA_W/...  : default sample width, coefficient width and tap count
//   - COEF_RESET      : value every coefficient takes at reset. With it the
//                       filter powers up as a TAPS-sample moving sum.
package fir_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_TAPS   = 4;
    localparam int COEF_RESET = 1;

    // Smallest r with 2**r >= value. The loop has a fixed bound so it
    // evaluates at elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree
//   Purely combinational signed sum of TAPS terms. The terms are already
//   sign-extended to ACC_W, and ACC_W is wide enough to hold the full sum.
//   The sum is built as a balanced pairwise tree. The input count is padded
//   with zeros up to the next power of two.
// Ports
//   terms : TAPS signed addends, ACC_W bits each
//   sum   : signed sum, ACC_W bits
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int TAPS  = DEF_TAPS,
    parameter int ACC_W = 18
) (
    input  logic signed [ACC_W-1:0] terms [TAPS],
    output logic signed [ACC_W-1:0] sum
);

    localparam int LEVELS = clog2(TAPS);
    localparam int PAD    = 1 << LEVELS;

    logic signed [ACC_W-1:0] work [PAD];

    // Each pass folds pairs (2i, 2i+1) into slot i, halving the live width.
    // Writing slot i only after reading 2i and 2i+1 makes in-place
    // reduction safe.
    always_comb begin
        for (int i = 0; i < PAD; i++) begin
            work[i] = '0;
        end
        for (int i = 0; i < TAPS; i++) begin
            work[i] = terms[i];
        end
        for (int w = PAD / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                work[i] = work[2*i] + work[2*i+1];
            end
        end
        sum = work[0];
    end

endmodule

// File: rtl/fir_stream.sv
// fir_stream
//   Parametrised streaming FIR filter. It takes signed DATA_W-bit samples,
//   has TAPS taps with run-time programmable signed coefficients, and sums
//   products at full precision before the final width reduction.
//
//   Handshake: the interface is valid-only with no backpressure. A sample is
//   accepted at every rising edge where i_valid=1. Each result is presented
//   on o_y with o_valid high for exactly one cycle, two edges after its
//   sample was accepted. The downstream block must take it in that cycle.
//   Throughput is one sample per cycle.
//
//   Pipeline:
//     edge N   : sample enters the delay line x[0]
//     edge N+1 : products x[k]*c[k] are registered
//     edge N+2 : the adder-tree sum is width-reduced and registered onto o_y
//
//   Build option: FIR_SAT_EN.
//     Defined   : when OUT_W < ACC_W the sum saturates to the signed OUT_W range.
//     Undefined : the low OUT_W bits are kept (two's-complement wrap).
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   i_valid      i_x holds a sample to accept this cycle
//   i_x          signed sample, DATA_W bits
//   i_clear      synchronous flush of the delay line
//                (applied before a same-cycle sample)
//   i_coef_we    coefficient write strobe
//   i_coef_addr  tap index to write; indices >= TAPS are ignored
//   i_coef       signed coefficient, COEF_W bits
//   o_valid      o_y holds a new result this cycle
//   o_y          signed result, OUT_W bits; holds while o_valid=0
//
// TAPS must be >= 2 and OUT_W must not exceed ACC_W.
module fir_stream
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int OUT_W  = DATA_W + COEF_W + clog2(TAPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [DATA_W-1:0]      i_x,
    input  logic                   i_clear,
    input  logic                   i_coef_we,
    input  logic [clog2(TAPS)-1:0] i_coef_addr,
    input  logic [COEF_W-1:0]      i_coef,
    output logic                   o_valid,
    output logic [OUT_W-1:0]       o_y
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + clog2(TAPS);

    // ------------------------------------------------------------------
    // Delay line
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] x_q    [TAPS];
    logic signed [DATA_W-1:0] x_base [TAPS];
    logic signed [DATA_W-1:0] x_next [TAPS];

    // A clear is applied first, then any same-cycle sample shifts into the
    // cleared line. Clear with a sample therefore yields {i_x, 0, ..., 0}.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            x_base[k] = i_clear ? '0 : x_q[k];
        end
        for (int k = 0; k < TAPS; k++) begin
            x_next[k] = x_base[k];
        end
        if (i_valid) begin
            x_next[0] = i_x;
            for (int k = 1; k < TAPS; k++) begin
                x_next[k] = x_base[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= x_next[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Coefficient bank
    // ------------------------------------------------------------------
    // coef_q is the programmed bank. coef_eff_q lags it by one edge and is
    // the copy that stage 1 multiplies with. Stage 1 for a sample accepted
    // at edge N runs at N+1, so coef_eff_q then holds the bank as it stood
    // before edge N. A write and a sample at the same edge therefore pair
    // the sample with the old coefficient. The next sample sees the new one.
    logic signed [COEF_W-1:0] coef_q     [TAPS];
    logic signed [COEF_W-1:0] coef_eff_q [TAPS];

    // The write decode compares against each tap index, so an address
    // >= TAPS matches no entry and is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k]     <= COEF_W'(COEF_RESET);
                coef_eff_q[k] <= COEF_W'(COEF_RESET);
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (i_coef_we && (int'(i_coef_addr) == k)) begin
                    coef_q[k] <= i_coef;
                end
                coef_eff_q[k] <= coef_q[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: products
    // ------------------------------------------------------------------
    // accept_q marks that the delay line took a sample at the last edge.
    // Products are only reloaded then, which keeps them stable otherwise.
    // A clear is not tracked here: products already registered finish
    // their trip through stage 2 unchanged.
    logic                     accept_q;
    logic                     v1_q;
    logic signed [PROD_W-1:0] prod_q [TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accept_q <= 1'b0;
            v1_q     <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            accept_q <= i_valid;
            v1_q     <= accept_q;
            if (accept_q) begin
                for (int k = 0; k < TAPS; k++) begin
                    prod_q[k] <= PROD_W'(x_q[k]) * PROD_W'(coef_eff_q[k]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sum, width reduction, output register
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] terms [TAPS];
    logic signed [ACC_W-1:0] acc;
    logic [OUT_W-1:0]        y_next;
    logic [OUT_W-1:0]        y_q;
    logic                    valid_q;

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            terms[k] = ACC_W'(prod_q[k]);
        end
    end

    fir_adder_tree #(
        .TAPS  (TAPS),
        .ACC_W (ACC_W)
    ) u_adder_tree (
        .terms (terms),
        .sum   (acc)
    );

`ifdef FIR_SAT_EN
    // Signed OUT_W limits expressed at ACC_W. ~max equals -max-1, the
    // minimum. When OUT_W == ACC_W neither limit can be crossed, so this
    // reduces to a plain copy.
    localparam logic signed [ACC_W-1:0] Y_MAX =
        ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    always_comb begin
        if (acc > Y_MAX) begin
            y_next = OUT_W'(Y_MAX);
        end else if (acc < Y_MIN) begin
            y_next = OUT_W'(Y_MIN);
        end else begin
            y_next = acc[OUT_W-1:0];
        end
    end
`else
    always_comb begin
        y_next = acc[OUT_W-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            y_q     <= '0;
        end else begin
            valid_q <= v1_q;
            if (v1_q) begin
                y_q <= y_next;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_y     = y_q;

endmodule

// File: tb/tb_fir_stream.sv
// tb_fir_stream
//   Directed bench for fir_stream. Two instances are used: the default build
//   (OUT_W = ACC_W = 18) and an OUT_W = 8 build for width reduction. Each
//   instance has its own expected queue, filled by the driver tasks, and its
//   own monitor that pops on every o_valid pulse. The monitor checks both
//   the value and the edge the result lands on.
module tb_fir_stream;

    localparam int ACC_W = 18;
    localparam int O8_W  = 8;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    logic             v, clr, we;
    logic [7:0]       x, coef;
    logic [1:0]       addr;
    logic             o_valid;
    logic [ACC_W-1:0] o_y;

    logic             v8, clr8, we8;
    logic [7:0]       x8, coef8;
    logic [1:0]       addr8;
    logic             o_valid8;
    logic [O8_W-1:0]  o_y8;

    fir_stream dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (v),
        .i_x         (x),
        .i_clear     (clr),
        .i_coef_we   (we),
        .i_coef_addr (addr),
        .i_coef      (coef),
        .o_valid     (o_valid),
        .o_y         (o_y)
    );

    fir_stream #(.OUT_W(O8_W)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (v8),
        .i_x         (x8),
        .i_clear     (clr8),
        .i_coef_we   (we8),
        .i_coef_addr (addr8),
        .i_coef      (coef8),
        .o_valid     (o_valid8),
        .o_y         (o_y8)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] exp_q[$];
    int               exp_t_q[$];
    logic [O8_W-1:0]  exp8_q[$];
    int               exp8_t_q[$];
    int               n_vec  = 0;
    int               n_miss = 0;

    // Width-reduction expectations for 127*127 and -128*127 ramps over 4 taps.
`ifdef FIR_SAT_EN
    localparam logic [7:0] E8_POS [4] = '{8'h7f, 8'h7f, 8'h7f, 8'h7f};
    localparam logic [7:0] E8_NEG [4] = '{8'h80, 8'h80, 8'h80, 8'h80};
`else
    localparam logic [7:0] E8_POS [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    localparam logic [7:0] E8_NEG [4] = '{8'h80, 8'h00, 8'h80, 8'h00};
`endif

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step(input logic vv, input logic signed [7:0] xx,
                        input logic cc, input logic ww, input logic [1:0] aa,
                        input logic signed [7:0] kk, input logic chk,
                        input logic signed [ACC_W-1:0] e);
        v = vv; x = xx; clr = cc; we = ww; addr = aa; coef = kk;
        @(posedge clk);
        #1;
        if (chk) begin
            exp_q.push_back(e);
            exp_t_q.push_back(cyc + 2);
        end
        v = 1'b0; clr = 1'b0; we = 1'b0;
    endtask

    task automatic sample(input logic signed [7:0] xx, input logic signed [ACC_W-1:0] e);
        step(1'b1, xx, 1'b0, 1'b0, 2'd0, 8'sd0, 1'b1, e);
    endtask

    task automatic wr(input logic [1:0] aa, input logic signed [7:0] kk);
        step(1'b0, 8'sd0, 1'b0, 1'b1, aa, kk, 1'b0, '0);
    endtask

    task automatic clear_line();
        step(1'b0, 8'sd0, 1'b1, 1'b0, 2'd0, 8'sd0, 1'b0, '0);
    endtask

    task automatic step8(input logic vv, input logic signed [7:0] xx,
                         input logic cc, input logic ww, input logic [1:0] aa,
                         input logic signed [7:0] kk, input logic chk,
                         input logic [O8_W-1:0] e);
        v8 = vv; x8 = xx; clr8 = cc; we8 = ww; addr8 = aa; coef8 = kk;
        @(posedge clk);
        #1;
        if (chk) begin
            exp8_q.push_back(e);
            exp8_t_q.push_back(cyc + 2);
        end
        v8 = 1'b0; clr8 = 1'b0; we8 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitors (sample on the falling edge)
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] mon_e;
    int               mon_t;
    logic [O8_W-1:0]  mon8_e;
    int               mon8_t;

    always @(negedge clk) begin
        if (!rst && o_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL out18_unexpected: o_y=%0d at edge %0d, expected no result", $signed(o_y), cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = exp_t_q.pop_front();
                if (o_y !== mon_e || cyc != mon_t) begin
                    n_miss++;
                    $display("FAIL out18: o_y=%0d at edge %0d, expected %0d at edge %0d",
                             $signed(o_y), cyc, $signed(mon_e), mon_t);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && o_valid8) begin
            n_vec++;
            if (exp8_q.size() == 0) begin
                n_miss++;
                $display("FAIL out8_unexpected: o_y=%0h at edge %0d, expected no result", o_y8, cyc);
            end else begin
                mon8_e = exp8_q.pop_front();
                mon8_t = exp8_t_q.pop_front();
                if (o_y8 !== mon8_e || cyc != mon8_t) begin
                    n_miss++;
                    $display("FAIL out8: o_y=%0h at edge %0d, expected %0h at edge %0d",
                             o_y8, cyc, mon8_e, mon8_t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        v = 0; x = 0; clr = 0; we = 0; addr = 0; coef = 0;
        v8 = 0; x8 = 0; clr8 = 0; we8 = 0; addr8 = 0; coef8 = 0;

        // Reset state
        idle(3);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_y", 32'(o_y), 32'd0);
        check("rst_valid8", 32'(o_valid8), 32'd0);
        rst = 1'b0;
        idle(2);
        check("post_rst_y", 32'(o_y), 32'd0);

        // 1: moving sum with reset coefficients
        sample(8'sd1, 1);
        sample(8'sd0, 1);
        sample(8'sd1, 2);
        sample(8'sd1, 3);
        sample(8'sd0, 2);
        idle(4);

        // 2: programmed coefficients, impulse, then the extreme product
        wr(2'd0, 8'sd2);
        wr(2'd1, -8'sd1);
        wr(2'd2, 8'sd0);
        wr(2'd3, 8'sd3);
        clear_line();
        sample(8'sd10, 20);
        sample(8'sd0, -10);
        sample(8'sd0, 0);
        sample(8'sd0, 30);
        wr(2'd0, -8'sd128);
        clear_line();
        sample(-8'sd128, 16384);
        idle(3);
        for (int k = 0; k < 4; k++) wr(2'(k), 8'sd1);

        // 3: gaps in i_valid leave the delay line untouched
        clear_line();
        sample(8'sd1, 1);
        idle(3);
        sample(8'sd2, 3);
        idle(4);

        // 4: clear with a simultaneous sample while results are in flight
        clear_line();
        sample(8'sd5, 5);
        sample(8'sd5, 10);
        sample(8'sd5, 15);
        step(1'b1, 8'sd7, 1'b1, 1'b0, 2'd0, 8'sd0, 1'b1, 7);
        sample(8'sd1, 8);
        idle(4);

        // 5: coefficient write in the same cycle as a sample
        clear_line();
        sample(8'sd2, 2);
        step(1'b1, 8'sd3, 1'b0, 1'b1, 2'd0, 8'sd4, 1'b1, 5);
        sample(8'sd3, 17);
        idle(3);
        wr(2'd0, 8'sd1);

        // 6: OUT_W = 8 width reduction
        for (int k = 0; k < 4; k++) step8(1'b0, 8'sd0, 1'b0, 1'b1, 2'(k), 8'sd127, 1'b0, '0);
        for (int k = 0; k < 4; k++) step8(1'b1, 8'sd127, 1'b0, 1'b0, 2'd0, 8'sd0, 1'b1, E8_POS[k]);
        step8(1'b0, 8'sd0, 1'b1, 1'b0, 2'd0, 8'sd0, 1'b0, '0);
        for (int k = 0; k < 4; k++) step8(1'b1, -8'sd128, 1'b0, 1'b0, 2'd0, 8'sd0, 1'b1, E8_NEG[k]);
        idle(4);

        // Reset mid-stream: a visible result and one in flight are discarded
        clear_line();
        step(1'b1, 8'sd4, 1'b0, 1'b0, 2'd0, 8'sd0, 1'b0, '0);
        step(1'b1, 8'sd6, 1'b0, 1'b0, 2'd0, 8'sd0, 1'b0, '0);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(o_valid), 32'd1);
        check("pre_rst_y", 32'(o_y), 32'd4);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_y", 32'(o_y), 32'd0);
        check("async_rst_y8", 32'(o_y8), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(5);
        check("no_stale_y", 32'(o_y), 32'd0);
        sample(8'sd1, 1);

        // Drain and confirm every expected result arrived
        for (int i = 0; i < 50 && (exp_q.size() != 0 || exp8_q.size() != 0); i++) begin
            @(posedge clk);
        end
        idle(4);
        check("drain18", 32'(exp_q.size()), 32'd0);
        check("drain8", 32'(exp8_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
